sine_quadrant_lut: RTL and testbench

- Downstream stage of the NCO phase accumulator.
- Reassembles the 12-bit folded phase address, which arrives as six 2-bit chunks LSB-first after each `vld_in` pulse.
- Applies the quadrant fold and sign-invert flag, reads a 65-entry quarter-wave sine ROM, and emits one signed 16-bit sample per 7-cycle frame.
- Sits between the phase accumulator and the DAC/output formatter on the single-chip NCO board.

---
 rtl/sine_quadrant_lut.sv | 255 +++++++++++++++++++++++++
 tb/tb_sine_quadrant_lut.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sine_quadrant_lut.sv
// Collects six 2-bit phase chunks into a 12-bit folded address, applies
// the quadrant fold and sign flag, and looks up a quarter-wave sine ROM.
// Ports: clk, rst_n (async, active-low), en, vld_in, a_in[1:0], is_in
//   -> sample[15:0] (signed), vld_out (strobe), err (sticky).
// Build option: SINE_LUT_INTERP_EN adds a linear-interpolation stage.
module sine_quadrant_lut #(
    parameter int W_OUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             vld_in,
    input  logic [1:0]       a_in,
    input  logic             is_in,
    output logic [W_OUT-1:0] sample,
    output logic             vld_out,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, COLL, WAIT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [11:0]      addr_q, addr_d;
    logic             err_q, err_d;
    logic             v1_q, v1_d;
    logic             neg1_q, neg1_d;
    logic [14:0]      rom0_q, rom0_d;
    logic [W_OUT-1:0] sample_q, sample_d;
    logic             vld_out_q, vld_out_d;

    logic             launch, partial, illegal, neg;
    logic [10:0]      m;
    logic [14:0]      mag_out;
    logic             neg_out, v_out;

`ifdef SINE_LUT_INTERP_EN
    logic [14:0]      rom1_q, rom1_d;
    logic [3:0]       f1_q, f1_d;
    logic             v2_q, v2_d;
    logic             neg2_q, neg2_d;
    logic [14:0]      mag2_q, mag2_d;
    logic [14:0]      diff;
    logic [18:0]      prod;
`else
    logic             unused_f;
    assign unused_f = ^m[3:0];
`endif

    function automatic logic [14:0] rom_f(input logic [6:0] k);
        case (k)
            7'd0:  rom_f = 15'd0;
            7'd1:  rom_f = 15'd804;
            7'd2:  rom_f = 15'd1608;
            7'd3:  rom_f = 15'd2410;
            7'd4:  rom_f = 15'd3212;
            7'd5:  rom_f = 15'd4011;
            7'd6:  rom_f = 15'd4808;
            7'd7:  rom_f = 15'd5602;
            7'd8:  rom_f = 15'd6393;
            7'd9:  rom_f = 15'd7179;
            7'd10: rom_f = 15'd7962;
            7'd11: rom_f = 15'd8739;
            7'd12: rom_f = 15'd9512;
            7'd13: rom_f = 15'd10278;
            7'd14: rom_f = 15'd11039;
            7'd15: rom_f = 15'd11793;
            7'd16: rom_f = 15'd12539;
            7'd17: rom_f = 15'd13279;
            7'd18: rom_f = 15'd14010;
            7'd19: rom_f = 15'd14732;
            7'd20: rom_f = 15'd15446;
            7'd21: rom_f = 15'd16151;
            7'd22: rom_f = 15'd16846;
            7'd23: rom_f = 15'd17530;
            7'd24: rom_f = 15'd18204;
            7'd25: rom_f = 15'd18868;
            7'd26: rom_f = 15'd19519;
            7'd27: rom_f = 15'd20159;
            7'd28: rom_f = 15'd20787;
            7'd29: rom_f = 15'd21403;
            7'd30: rom_f = 15'd22005;
            7'd31: rom_f = 15'd22594;
            7'd32: rom_f = 15'd23170;
            7'd33: rom_f = 15'd23731;
            7'd34: rom_f = 15'd24279;
            7'd35: rom_f = 15'd24811;
            7'd36: rom_f = 15'd25329;
            7'd37: rom_f = 15'd25832;
            7'd38: rom_f = 15'd26319;
            7'd39: rom_f = 15'd26790;
            7'd40: rom_f = 15'd27245;
            7'd41: rom_f = 15'd27683;
            7'd42: rom_f = 15'd28105;
            7'd43: rom_f = 15'd28510;
            7'd44: rom_f = 15'd28898;
            7'd45: rom_f = 15'd29268;
            7'd46: rom_f = 15'd29621;
            7'd47: rom_f = 15'd29956;
            7'd48: rom_f = 15'd30273;
            7'd49: rom_f = 15'd30571;
            7'd50: rom_f = 15'd30852;
            7'd51: rom_f = 15'd31113;
            7'd52: rom_f = 15'd31356;
            7'd53: rom_f = 15'd31580;
            7'd54: rom_f = 15'd31785;
            7'd55: rom_f = 15'd31971;
            7'd56: rom_f = 15'd32137;
            7'd57: rom_f = 15'd32285;
            7'd58: rom_f = 15'd32412;
            7'd59: rom_f = 15'd32521;
            7'd60: rom_f = 15'd32609;
            7'd61: rom_f = 15'd32678;
            7'd62: rom_f = 15'd32728;
            7'd63: rom_f = 15'd32757;
            7'd64: rom_f = 15'd32767;
            default: rom_f = 15'd0;
        endcase
    endfunction

    // Quadrant fold; 01/10 are illegal and fold like 00.
    always_comb begin
        m       = {1'b0, addr_q[9:0]};
        neg     = is_in;
        illegal = 1'b0;
        unique case (addr_q[11:10])
            2'b11: begin
                m   = 11'd1024 - {1'b0, addr_q[9:0]};
                neg = ~is_in;
            end
            2'b01, 2'b10: illegal = 1'b1;
            default: ;
        endcase
    end

    // Frame collector; the vld_in that launches a frame also opens the next.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        launch  = 1'b0;
        partial = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: if (vld_in) begin
                    state_d = COLL;
                    cnt_d   = '0;
                    addr_d  = '0;
                end
                COLL: if (vld_in) begin
                    partial = 1'b1;
                    cnt_d   = '0;
                    addr_d  = '0;
                end else begin
                    addr_d[{cnt_q, 1'b0} +: 2] = a_in;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd5) state_d = WAIT;
                end
                WAIT: if (vld_in) begin
                    launch  = 1'b1;
                    state_d = COLL;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        v1_d   = launch;
        neg1_d = neg1_q;
        rom0_d = rom0_q;
        err_d  = err_q | partial | (launch & illegal);
        if (launch) begin
            neg1_d = neg;
            rom0_d = rom_f(m[10:4]);
        end
`ifdef SINE_LUT_INTERP_EN
        rom1_d = rom1_q;
        f1_d   = f1_q;
        if (launch) begin
            // k=64 only occurs with f=0, so the k+1 entry is weighted by 0.
            rom1_d = rom_f(m[10:4] + 7'd1);
            f1_d   = m[3:0];
        end
        diff    = rom1_q - rom0_q;
        prod    = {4'b0, diff} * {15'b0, f1_q};
        v2_d    = v1_q & en;
        neg2_d  = v1_q ? neg1_q : neg2_q;
        mag2_d  = v1_q ? rom0_q + prod[18:4] : mag2_q;
        mag_out = mag2_q;
        neg_out = neg2_q;
        v_out   = v2_q;
`else
        mag_out = rom0_q;
        neg_out = neg1_q;
        v_out   = v1_q;
`endif
        vld_out_d = v_out & en;
        sample_d  = sample_q;
        if (v_out & en) begin
            sample_d = neg_out ? W_OUT'(0) - W_OUT'(mag_out)
                               : W_OUT'(mag_out);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            v1_q      <= 1'b0;
            neg1_q    <= 1'b0;
            rom0_q    <= '0;
            sample_q  <= '0;
            vld_out_q <= 1'b0;
`ifdef SINE_LUT_INTERP_EN
            rom1_q    <= '0;
            f1_q      <= '0;
            v2_q      <= 1'b0;
            neg2_q    <= 1'b0;
            mag2_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            v1_q      <= v1_d;
            neg1_q    <= neg1_d;
            rom0_q    <= rom0_d;
            sample_q  <= sample_d;
            vld_out_q <= vld_out_d;
`ifdef SINE_LUT_INTERP_EN
            rom1_q    <= rom1_d;
            f1_q      <= f1_d;
            v2_q      <= v2_d;
            neg2_q    <= neg2_d;
            mag2_q    <= mag2_d;
`endif
        end
    end

    assign sample  = sample_q;
    assign vld_out = vld_out_q;
    assign err     = err_q;

endmodule

// File: tb/tb_sine_quadrant_lut.sv
// Directed bench for sine_quadrant_lut: framed chunk stimulus,
// hand-computed samples, latency, spacing, error and reset checks.
module tb_sine_quadrant_lut;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        vld_in;
    logic [1:0]  a_in;
    logic        is_in;
    logic [15:0] sample;
    logic        vld_out;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] got_s[$];
    int          got_c[$];
    int          lch[$];
    logic [11:0] va[$];
    logic        vs[$];

`ifdef SINE_LUT_INTERP_EN
    localparam int          LAT  = 3;
    localparam logic [15:0] E3FF = 16'd32766;
`else
    localparam int          LAT  = 2;
    localparam logic [15:0] E3FF = 16'd32757;
`endif

    sine_quadrant_lut dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .vld_in  (vld_in),
        .a_in    (a_in),
        .is_in   (is_in),
        .sample  (sample),
        .vld_out (vld_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] gs(input int i);
        if (i < got_s.size()) return got_s[i];
        return 16'hxxxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (vld_out === 1'b1) begin
            got_s.push_back(sample);
            got_c.push_back(cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] a,
                         input logic s);
        vld_in = v;
        a_in   = a;
        is_in  = s;
        tick();
    endtask

    task automatic frame(input logic [11:0] ad, input logic s);
        drive(1'b1, 2'b00, s);
        for (int k = 0; k < 6; k++) drive(1'b0, ad[2*k +: 2], 1'b0);
    endtask

    task automatic add(input logic [11:0] ad, input logic s);
        va.push_back(ad);
        vs.push_back(s);
    endtask

    // Frames back to back; each frame's sign flag rides on the next
    // vld_in. Ends with an en drop to abort the trailing frame.
    task automatic run_frames();
        got_s.delete();
        got_c.delete();
        lch.delete();
        for (int i = 0; i < va.size(); i++) begin
            if (i > 0) lch.push_back(cyc);
            frame(va[i], (i > 0) ? vs[i-1] : 1'b0);
        end
        lch.push_back(cyc);
        drive(1'b1, 2'b00, vs[vs.size()-1]);
        repeat (6) drive(1'b0, 2'b00, 1'b0);
        en = 1'b0;
        drive(1'b0, 2'b00, 1'b0);
        en = 1'b1;
        va.delete();
        vs.delete();
    endtask

    task automatic chk_lat(input string tag);
        int nb;
        nb = 0;
        for (int i = 0; i < got_c.size() && i < lch.size(); i++)
            if (got_c[i] - lch[i] != LAT) nb++;
        chk(tag, nb, 0);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        en     = 1'b1;
        vld_in = 1'b0;
        a_in   = 2'b00;
        is_in  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int sp_bad;
        int mono_bad;

        rst_n  = 1'b0;
        en     = 1'b1;
        vld_in = 1'b0;
        a_in   = 2'b00;
        is_in  = 1'b0;
        #2;
        chk("rst_sample", sample, 16'h0000);
        chk("rst_vld", vld_out, 1'b0);
        chk("rst_err", err, 1'b0);
        do_reset();

        add(12'h200, 1'b1);
        run_frames();
        chk("t1_count", got_s.size(), 1);
        chk("t1_sample", gs(0), 16'hA57E);
        chk_lat("t1_latency");

        add(12'hC00, 1'b0);
        add(12'h000, 1'b0);
        add(12'h3FF, 1'b0);
        run_frames();
        chk("t2_count", got_s.size(), 3);
        chk("t2_c00", gs(0), 16'h8001);
        chk("t2_000", gs(1), 16'h0000);
        chk("t2_3ff", gs(2), E3FF);
        chk_lat("t2_latency");

        for (int i = 0; i < 64; i++) add(12'(i * 16), 1'b0);
        run_frames();
        chk("sw_count", got_s.size(), 64);
        sp_bad   = 0;
        mono_bad = 0;
        for (int i = 1; i < got_s.size(); i++) begin
            if (got_c[i] - got_c[i-1] != 7) sp_bad++;
            if ($signed(got_s[i]) < $signed(got_s[i-1])) mono_bad++;
        end
        chk("sw_spacing", sp_bad, 0);
        chk("sw_monotonic", mono_bad, 0);
        chk("sw_k0", gs(0), 16'd0);
        chk("sw_k16", gs(16), 16'd12539);
        chk("sw_k32", gs(32), 16'd23170);
        chk("sw_k48", gs(48), 16'd30273);
        chk("sw_k63", gs(63), 16'd32757);
        chk_lat("sw_latency");
        chk("sw_err", err, 1'b0);

        drive(1'b1, 2'b00, 1'b0);
        repeat (3) drive(1'b0, 2'b01, 1'b0);
        add(12'h200, 1'b0);
        run_frames();
        chk("pf_err", err, 1'b1);
        chk("pf_count", got_s.size(), 1);
        chk("pf_sample", gs(0), 16'h5A82);
        chk("en_hold_smp", sample, 16'h5A82);
        chk("en_vld_low", vld_out, 1'b0);

        do_reset();
        add(12'h400, 1'b0);
        add(12'h200, 1'b0);
        run_frames();
        chk("iq_count", got_s.size(), 2);
        chk("iq_sample", gs(0), 16'h0000);
        chk("iq_next", gs(1), 16'h5A82);
        chk("iq_err", err, 1'b1);

        drive(1'b1, 2'b00, 1'b0);
        repeat (3) drive(1'b0, 2'b11, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mr_sample", sample, 16'h0000);
        chk("mr_err", err, 1'b0);
        chk("mr_vld", vld_out, 1'b0);
        tick();
        rst_n = 1'b1;
        got_s.delete();
        got_c.delete();
        repeat (2) drive(1'b0, 2'b11, 1'b0);
        drive(1'b1, 2'b00, 1'b0);
        repeat (5) drive(1'b0, 2'b00, 1'b0);
        chk("mr_no_out", got_s.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
